// File: rtl/ysyx_24100029_arb_pkg.sv
// Shared types and constants for the two-master AXI4 memory arbiter.
package ysyx_24100029_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_M0 = 2'd1,
    RD_M1 = 2'd2,
    WR_M1 = 2'd3
  } arb_state_e;

  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;

  localparam int STARVE_W = 8;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

endpackage

// File: rtl/ysyx_24100029_arb_pick.sv
// Next-grant decision evaluated in IDLE. ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise LSU-first priority with an icache starvation escape.
module ysyx_24100029_arb_pick
  import ysyx_24100029_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic                r0,
  input  logic                r1r,
  input  logic                r1w,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic                rr_ptr,
`else
  input  logic [STARVE_W-1:0] starve_cnt,
`endif
  output logic [1:0]          next_state
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam int unused_starve_limit = STARVE_LIMIT;
`endif

  always_comb begin
    // NOTE: default assigned first so every path drives next_state and no latch is inferred.
    next_state = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
    // The master not granted last time wins a tie; inside M1 a write beats a read.
    if (r0 && (rr_ptr == M1_ID || !(r1r || r1w))) next_state = RD_M0;
    else if (r1w)                                  next_state = WR_M1;
    else if (r1r)                                  next_state = RD_M1;
`else
    if (r0 && starve_cnt >= STARVE_W'(STARVE_LIMIT)) next_state = RD_M0;
    else if (r1w)                                    next_state = WR_M1;
    else if (r1r)                                    next_state = RD_M1;
    else if (r0)                                     next_state = RD_M0;
`endif
  end

endmodule

// File: rtl/ysyx_24100029_mem_arbiter.sv
// Two-master AXI4 arbiter: icache (M0, read-only) and LSU (M1) share one memory port.
// Grant held until the final R/B beat. Define ARB_ROUND_ROBIN_EN for round-robin fairness.
module ysyx_24100029_mem_arbiter
  import ysyx_24100029_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clock,
  input  logic              reset,
  // M0: icache
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic [ID_W-1:0]   m0_rid,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  // M1: LSU
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic [ID_W-1:0]   m1_rid,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [ID_W-1:0]   m1_awid,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [1:0]        m1_bresp,
  output logic [ID_W-1:0]   m1_bid,
  // Shared memory port
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0]   s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [ID_W-1:0]   s_rid,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [ID_W-1:0]   s_awid,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wstrb,
  output logic              s_wlast,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [1:0]        s_bresp,
  input  logic [ID_W-1:0]   s_bid,
  // Status
  output logic              grant_id,
  output logic              busy
);

  arb_state_e state;
  arb_state_e next_st;
  logic [1:0] next_pick;
  logic       addr_done;  // address accepted; blocks a second AR/AW inside one grant
  logic       rd0, rd1, wr1;

  logic unused_m0_write;
  assign unused_m0_write = m0_awvalid | m0_wvalid | m0_bready;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;
`else
  logic [STARVE_W-1:0] starve_cnt;
`endif

  ysyx_24100029_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .r0         (m0_arvalid),
    .r1r        (m1_arvalid),
    .r1w        (m1_awvalid),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_ptr     (rr_ptr),
`else
    .starve_cnt (starve_cnt),
`endif
    .next_state (next_pick)
  );

  assign next_st = arb_state_e'(next_pick);

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments; the async reset drops any burst in flight.
    if (!reset) begin
      state     <= IDLE;
      addr_done <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr    <= M0_ID;
`else
      starve_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state     <= next_st;
          addr_done <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          if (next_st != IDLE) rr_ptr <= (next_st == RD_M0) ? M0_ID : M1_ID;
`else
          if (next_st == RD_M0)
            starve_cnt <= '0;
          else if (m0_arvalid && (next_st == RD_M1 || next_st == WR_M1) && starve_cnt != '1)
            starve_cnt <= starve_cnt + 1'b1;
`endif
        end
        RD_M0, RD_M1: begin
          if (s_arvalid && s_arready) addr_done <= 1'b1;
          if (s_rvalid && s_rready && s_rlast) state <= IDLE;
        end
        WR_M1: begin
          if (s_awvalid && s_awready) addr_done <= 1'b1;
          if (s_bvalid && s_bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd0      = (state == RD_M0);
  assign rd1      = (state == RD_M1);
  assign wr1      = (state == WR_M1);
  assign busy     = (state != IDLE);
  assign grant_id = (rd1 || wr1) ? M1_ID : M0_ID;

  // AR channel: payload follows the owner, valid/ready only while the address is pending.
  assign s_arvalid  = ~addr_done & ((rd0 & m0_arvalid) | (rd1 & m1_arvalid));
  assign s_araddr   = rd0 ? m0_araddr  : m1_araddr;
  assign s_arid     = rd0 ? m0_arid    : m1_arid;
  assign s_arlen    = rd0 ? m0_arlen   : m1_arlen;
  assign s_arsize   = rd0 ? m0_arsize  : m1_arsize;
  assign s_arburst  = rd0 ? m0_arburst : m1_arburst;
  assign m0_arready = rd0 & ~addr_done & s_arready;
  assign m1_arready = rd1 & ~addr_done & s_arready;

  assign m0_rvalid = rd0 & s_rvalid;
  assign m1_rvalid = rd1 & s_rvalid;
  assign s_rready  = (rd0 & m0_rready) | (rd1 & m1_rready);
  assign m0_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m0_rlast  = s_rlast;
  assign m0_rid    = s_rid;
  assign m1_rdata  = s_rdata;
  assign m1_rresp  = s_rresp;
  assign m1_rlast  = s_rlast;
  assign m1_rid    = s_rid;

  assign s_awvalid  = wr1 & ~addr_done & m1_awvalid;
  assign m1_awready = wr1 & ~addr_done & s_awready;
  assign s_awaddr   = m1_awaddr;
  assign s_awid     = m1_awid;
  assign s_awlen    = m1_awlen;
  assign s_awsize   = m1_awsize;
  assign s_awburst  = m1_awburst;

  assign s_wvalid  = wr1 & m1_wvalid;
  assign m1_wready = wr1 & s_wready;
  assign s_wdata   = m1_wdata;
  assign s_wstrb   = m1_wstrb;
  assign s_wlast   = m1_wlast;

  assign m1_bvalid = wr1 & s_bvalid;
  assign s_bready  = wr1 & m1_bready;
  assign m1_bresp  = s_bresp;
  assign m1_bid    = s_bid;

  assign m0_awready = 1'b0;
  assign m0_wready  = 1'b0;
  assign m0_bvalid  = 1'b0;

endmodule
